instr_prefetch_unit: RTL
========================

INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named CLK and RST.
REQ-002 Parameter ADDRESS_WIDTH, default 32, SHALL set the PC, memory address and EPC width.
REQ-003 Parameter INSTR_WIDTH, default 32, SHALL set the instruction word width.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set the prefetch queue entries; it is a power of 2 and at least 2.
REQ-005 Parameter RESET_VECTOR, default 0, SHALL set the first fetch address.
REQ-006 Parameter EXC_VECTOR, default 'h180, SHALL set the exception handler address.
REQ-007 Ports (name, direction, width, meaning) SHALL be:
- CLK in 1: clock.
- RST in 1: async reset, active high.
- MEM_REQ out 1: fetch request.
- MEM_ADDR out ADDRESS_WIDTH: fetch address.
- MEM_ACK in 1: read data valid this cycle.
- MEM_RDATA in INSTR_WIDTH: fetched word.
- IR_VALID out 1: head entry valid.
- IR_READY in 1: decode consumes head.
- Instr out INSTR_WIDTH: head instruction.
- Instr_PC out ADDRESS_WIDTH: head instruction address.
- REDIRECT in 1: branch/jump taken.
- REDIRECT_ADDR in ADDRESS_WIDTH: redirect target.
- EXC in 1: exception request.
- PC_OUT out ADDRESS_WIDTH: next fetch PC (FPC).
- EPC_OUT out ADDRESS_WIDTH: saved exception PC.

Function
REQ-008 At most one request SHALL be outstanding; MEM_REQ and MEM_ADDR SHALL be held stable from assertion until the cycle MEM_ACK is sampled high.
REQ-009 MEM_ACK SHALL be accepted in the same cycle as MEM_REQ assertion (zero-wait memory) or in any later cycle.
REQ-010 In state RUN, MEM_REQ SHALL assert only when queue count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs that cycle.
REQ-011 On an accepted ACK in RUN, {MEM_RDATA, MEM_ADDR} SHALL be pushed and FPC SHALL advance by 4, wrapping modulo 2^ADDRESS_WIDTH.
REQ-012 A pushed word SHALL appear on Instr/IR_VALID on the next cycle; there is no combinational path from MEM_RDATA to Instr.
REQ-013 IR_VALID SHALL equal (count != 0); the head SHALL pop on IR_VALID & IR_READY; a simultaneous push and pop SHALL leave count unchanged.
REQ-014 On REDIRECT, the queue SHALL flush, FPC SHALL load {REDIRECT_ADDR[AW-1:2], 2'b00}, and IR_VALID SHALL be 0 the next cycle.
REQ-015 If REDIRECT occurs while a request is outstanding and un-acked, the state SHALL go to DRAIN: the old request is held until ACK, the data is discarded, then the state returns to RUN.
REQ-016 A REDIRECT coincident with an ACK SHALL discard that data; the state SHALL remain RUN.
REQ-017 A REDIRECT during DRAIN SHALL update FPC only; the state SHALL remain DRAIN.
REQ-018 EXC SHALL have priority over REDIRECT and SHALL act as a redirect to EXC_VECTOR; EPC SHALL load Instr_PC if IR_VALID, else FPC.
REQ-019 The states SHALL be exactly RUN and DRAIN.

Reset
REQ-020 RST SHALL asynchronously set: FPC=RESET_VECTOR, queue empty, state RUN, EPC_OUT=0, MEM_REQ=0, IR_VALID=0, Instr=0, Instr_PC=0.
REQ-021 The first MEM_REQ SHALL assert in the first clock after RST deasserts, with MEM_ADDR=RESET_VECTOR.
REQ-022 An in-flight request aborted by RST SHALL be forgotten; an ACK in the first post-reset cycle SHALL be treated as the response to the new request.

Configuration
REQ-023 With IFU_EPC_EN defined, the EXC/EPC behaviour of REQ-018 SHALL be present.
REQ-024 Without IFU_EPC_EN, the EXC input SHALL be ignored, EPC_OUT SHALL be tied to 0, and no EPC register SHALL be built; the port list SHALL be unchanged.

Structure
REQ-025 Package ifu_pkg SHALL hold the state encoding (RUN, DRAIN) and constant INSTR_BYTES=4.
REQ-026 The queue SHALL be sub-module instr_fifo: synchronous, parametrised width and depth, with a flush input; it SHALL store {Instr_PC, Instr}.

Verification
REQ-027 Zero-wait memory with IR_READY=1: after reset, MEM_ADDR SHALL be 0,4,8,... on consecutive cycles, and Instr_PC SHALL trail by one cycle.
REQ-028 IR_READY=0 and FIFO_DEPTH=4: after 4 pushes, MEM_REQ SHALL deassert; one pop SHALL re-enable exactly one fetch.
REQ-029 REDIRECT to 'h103 while a 3-cycle-latency request is outstanding: state SHALL enter DRAIN, the stale word SHALL be dropped, and the next MEM_ADDR SHALL be 'h100.
REQ-030 EXC with head Instr_PC='h40 coincident with REDIRECT: EPC_OUT SHALL be 'h40, the next MEM_ADDR SHALL be 'h180, and the queue SHALL be empty.
REQ-031 RST asserted mid-request: outputs SHALL clear immediately; after release, MEM_ADDR SHALL be RESET_VECTOR.
REQ-032 FPC='hFFFFFFFC with ACK: the next MEM_ADDR SHALL be 0 (wrap-around).

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encoding and
// the fixed instruction size used to advance the fetch PC.
package ifu_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    // Fetch FSM states
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous prefetch queue with flush. The head entry is presented from a
// register array, so there is no combinational path from write data to output.
module instr_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A push into a full queue is only legal when a pop frees a slot this cycle
    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != CW'(DEPTH)) | w_pop_ok);

    // Queue storage, pointers and occupancy; flush empties without touching data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: keeps one memory read outstanding at a time and
// buffers fetched words with their PCs for decode. A redirect that arrives while
// a read is in flight moves to DRAIN, which waits out and discards that read.
// Optional feature: define IFU_EPC_EN to build the exception PC capture and
// exception redirect; otherwise EXC is ignored and EPC_OUT reads 0.
module instr_prefetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               INSTR_WIDTH   = 32,
    parameter int unsigned               FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_VECTOR  = '0,
    parameter logic [ADDRESS_WIDTH-1:0]  EXC_VECTOR    = 'h180
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic                      MEM_REQ,
    output logic [ADDRESS_WIDTH-1:0]  MEM_ADDR,
    input  logic                      MEM_ACK,
    input  logic [INSTR_WIDTH-1:0]    MEM_RDATA,
    output logic                      IR_VALID,
    input  logic                      IR_READY,
    output logic [INSTR_WIDTH-1:0]    Instr,
    output logic [ADDRESS_WIDTH-1:0]  Instr_PC,
    input  logic                      REDIRECT,
    input  logic [ADDRESS_WIDTH-1:0]  REDIRECT_ADDR,
    input  logic                      EXC,
    output logic [ADDRESS_WIDTH-1:0]  PC_OUT,
    output logic [ADDRESS_WIDTH-1:0]  EPC_OUT
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned IW = INSTR_WIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [0:0]      r_state;
    logic [AW-1:0]   r_fpc;
    logic [AW-1:0]   r_drain_addr;

    logic [CW-1:0]   w_count;
    logic [AW+IW-1:0] w_head;
    logic            w_pop;
    logic            w_ack;
    logic            w_exc;
    logic            w_redir;
    logic [AW-1:0]   w_target;
    logic            w_push;
    logic [AW-1:0]   w_unused_redir_lsb;

    assign w_unused_redir_lsb = {{(AW-2){1'b0}}, REDIRECT_ADDR[1:0]};

    assign IR_VALID = (w_count != '0);
    assign w_pop    = IR_VALID & IR_READY;

    // Request while there is room (or room being made); DRAIN keeps the old read up.
    // RST gating keeps MEM_REQ low for the whole reset pulse.
    assign MEM_REQ  = ~RST & ((r_state == S_DRAIN) | (w_count != CW'(FIFO_DEPTH)) | w_pop);
    assign MEM_ADDR = (r_state == S_DRAIN) ? r_drain_addr : r_fpc;
    assign w_ack    = MEM_REQ & MEM_ACK;

    assign w_redir  = REDIRECT | w_exc;
    assign w_target = w_exc ? EXC_VECTOR : {REDIRECT_ADDR[AW-1:2], 2'b00};
    assign w_push   = (r_state == S_RUN) & w_ack & ~w_redir;

`ifdef IFU_EPC_EN
    logic [AW-1:0] r_epc;

    assign w_exc = EXC;

    // Capture the PC of the oldest unexecuted instruction on an exception
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_epc <= '0;
        end else if (w_exc) begin
            r_epc <= IR_VALID ? Instr_PC : r_fpc;
        end
    end

    assign EPC_OUT = r_epc;
`else
    logic w_unused_exc;

    assign w_unused_exc = EXC;
    assign w_exc        = 1'b0;
    assign EPC_OUT      = '0;
`endif

    // Fetch PC and RUN/DRAIN state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_RUN;
            r_fpc        <= RESET_VECTOR;
            r_drain_addr <= '0;
        end else begin
            if (w_redir) begin
                r_fpc <= w_target;
            end else if ((r_state == S_RUN) && w_ack) begin
                r_fpc <= r_fpc + AW'(INSTR_BYTES);
            end
            case (r_state)
                S_RUN: begin
                    // Memory already saw this address, so it must be held until acked
                    if (w_redir && MEM_REQ && !MEM_ACK) begin
                        r_state      <= S_DRAIN;
                        r_drain_addr <= r_fpc;
                    end
                end
                S_DRAIN: begin
                    if (MEM_ACK) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    instr_fifo #(
        .WIDTH (AW + IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_flush (w_redir),
        .i_push  (w_push),
        .i_data  ({MEM_ADDR, MEM_RDATA}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign Instr_PC = w_head[AW+IW-1:IW];
    assign Instr    = w_head[IW-1:0];
    assign PC_OUT   = r_fpc;

endmodule
